mem_port_arbiter: RTL and testbench

//  Shares the processor's single-ported memory between the multi-cycle CPU control path and an

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the CPU control path and an external port.
// Handles locked EXT bursts, CPU-priority or round-robin selection, and EXT anti-starvation.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int CPU_PRIO   = 1,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 8,
  localparam int BW        = $clog2(MAX_BURST + 1),
  localparam int WW        = $clog2(STARVE_LIM + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          ext_req_i,
  input  logic          ext_we_i,
  input  logic          ext_lock_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_wdata_i,
  output logic          ext_gnt_o,
  output logic          ext_rvalid_o,
  output logic [DW-1:0] ext_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [1:0]    dbg_owner_o,
  output logic [WW-1:0] dbg_wait_cnt_o
);

  // Handshake: a requester holds req (and its addr/we/wdata) until it sees gnt in the same
  // cycle; the transfer happens in that cycle and read data is marked by rvalid one cycle later.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          last_ext_q, last_ext_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          cpu_rvalid_q, ext_rvalid_q;
  logic          cpu_rq, ext_rq;
  logic          gnt_cpu, gnt_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      last_ext_q   <= 1'b1;
      burst_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_ext_q   <= last_ext_d;
      burst_cnt_q  <= burst_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= gnt_cpu & ~cpu_we_i;
      ext_rvalid_q <= gnt_ext & ~ext_we_i;
    end
  end

  always_comb begin
    // Requests are masked while reset is held so no grant or memory strobe leaks out.
    cpu_rq      = cpu_req_i & ~reset;
    ext_rq      = ext_req_i & ~reset;
    gnt_cpu     = 1'b0;
    gnt_ext     = 1'b0;
    owner_d     = OWN_NONE;
    last_ext_d  = last_ext_q;
    burst_cnt_d = '0;
    wait_cnt_d  = '0;

    if (cpu_rq && ext_rq) begin
      if (wait_cnt_q == WW'(STARVE_LIM)) begin
        gnt_ext = 1'b1;
      end else if (owner_q == OWN_EXT && ext_lock_i && burst_cnt_q < BW'(MAX_BURST)) begin
        gnt_ext = 1'b1;
      end else if (CPU_PRIO != 0) begin
        gnt_cpu = 1'b1;
      end else if (last_ext_q) begin
        gnt_cpu = 1'b1;
      end else begin
        gnt_ext = 1'b1;
      end
    end else begin
      gnt_cpu = cpu_rq;
      gnt_ext = ext_rq;
    end

    if (gnt_cpu) begin
      owner_d    = OWN_CPU;
      last_ext_d = 1'b0;
    end else if (gnt_ext) begin
      owner_d    = OWN_EXT;
      last_ext_d = 1'b1;
      if (owner_q != OWN_EXT) begin
        burst_cnt_d = BW'(1);
      end else if (burst_cnt_q == BW'(MAX_BURST)) begin
        burst_cnt_d = burst_cnt_q;
      end else begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end
    end

    if (ext_rq && !gnt_ext) begin
      wait_cnt_d = (wait_cnt_q == WW'(STARVE_LIM)) ? wait_cnt_q : wait_cnt_q + WW'(1);
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    if (gnt_cpu) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_we_o    = cpu_we_i;
      mem_re_o    = ~cpu_we_i;
    end else if (gnt_ext) begin
      mem_addr_o  = ext_addr_i;
      mem_wdata_o = ext_wdata_i;
      mem_we_o    = ext_we_i;
      mem_re_o    = ~ext_we_i;
    end
  end

  assign cpu_gnt_o      = gnt_cpu;
  assign ext_gnt_o      = gnt_ext;
  assign cpu_rvalid_o   = cpu_rvalid_q;
  assign ext_rvalid_o   = ext_rvalid_q;
  assign cpu_rdata_o    = mem_rdata_i;
  assign ext_rdata_o    = mem_rdata_i;
  assign dbg_owner_o    = owner_q;
  assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a CPU-priority arbiter (index 0) and a round-robin arbiter (index 1) with identical
// stimulus; each has its own synchronous memory and is compared against a rule-level model.
module tb_mem_port_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int STV  = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata;

  logic          cpu_gnt[2], cpu_rvalid[2], ext_gnt[2], ext_rvalid[2];
  logic [DW-1:0] cpu_rdata[2], ext_rdata[2], mem_wdata[2], mem_rdata[2];
  logic [AW-1:0] mem_addr[2];
  logic          mem_we[2], mem_re[2];
  logic [1:0]    dbg_owner[2];
  logic [3:0]    dbg_wait[2];

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [DW-1:0] mem [256];

    mem_port_arbiter #(
      .AW(AW), .DW(DW), .CPU_PRIO((k == 0) ? 1 : 0), .MAX_BURST(MAXB), .STARVE_LIM(STV)
    ) u_dut (
      .clock(clock), .reset(reset),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_gnt_o(cpu_gnt[k]), .cpu_rvalid_o(cpu_rvalid[k]), .cpu_rdata_o(cpu_rdata[k]),
      .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_lock_i(ext_lock), .ext_addr_i(ext_addr),
      .ext_wdata_i(ext_wdata),
      .ext_gnt_o(ext_gnt[k]), .ext_rvalid_o(ext_rvalid[k]), .ext_rdata_o(ext_rdata[k]),
      .mem_addr_o(mem_addr[k]), .mem_wdata_o(mem_wdata[k]), .mem_we_o(mem_we[k]),
      .mem_re_o(mem_re[k]), .mem_rdata_i(mem_rdata[k]),
      .dbg_owner_o(dbg_owner[k]), .dbg_wait_cnt_o(dbg_wait[k])
    );

    always @(posedge clock) begin
      if (pl_en) begin
        mem[pl_addr] <= pl_data;
      end else begin
        if (mem_we[k]) mem[mem_addr[k]] <= mem_wdata[k];
        if (mem_re[k]) mem_rdata[k] <= mem[mem_addr[k]];
      end
    end
  end

  // Reference model: owner/last use 0=none, 1=CPU, 2=EXT.
  int            n_cmp = 0;
  int            n_fail = 0;
  int            m_owner[2], m_last[2], m_burst[2], m_wait[2];
  logic          exp_crv[2], exp_erv[2];
  logic [DW-1:0] exp_rd[2];
  logic [DW-1:0] shadow[2][256];

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_last[k] = 2; m_burst[k] = 0; m_wait[k] = 0;
      exp_crv[k] = 1'b0; exp_erv[k] = 1'b0;
    end
  endtask

  function automatic int pick(input int k);
    if (!cpu_req && !ext_req) return 0;
    if (!ext_req) return 1;
    if (!cpu_req) return 2;
    if (m_wait[k] == STV) return 2;
    if (m_owner[k] == 2 && ext_lock && m_burst[k] < MAXB) return 2;
    if (k == 0) return 1;
    return (m_last[k] == 2) ? 1 : 2;
  endfunction

  task automatic check_zero();
    for (int k = 0; k < 2; k++) begin
      check("rst_cpu_gnt", k, cpu_gnt[k], 0);
      check("rst_ext_gnt", k, ext_gnt[k], 0);
      check("rst_cpu_rvalid", k, cpu_rvalid[k], 0);
      check("rst_ext_rvalid", k, ext_rvalid[k], 0);
      check("rst_mem_addr", k, mem_addr[k], 0);
      check("rst_mem_wdata", k, mem_wdata[k], 0);
      check("rst_mem_we", k, mem_we[k], 0);
      check("rst_mem_re", k, mem_re[k], 0);
      check("rst_owner", k, dbg_owner[k], 0);
      check("rst_wait", k, dbg_wait[k], 0);
    end
  endtask

  // Entered just after a rising edge with inputs driven; returns just after the next one.
  task automatic cycle();
    int            g[2];
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we;
    for (int k = 0; k < 2; k++) g[k] = pick(k);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      a  = (g[k] == 1) ? cpu_addr  : (g[k] == 2) ? ext_addr  : '0;
      wd = (g[k] == 1) ? cpu_wdata : (g[k] == 2) ? ext_wdata : '0;
      we = (g[k] == 1) ? cpu_we    : (g[k] == 2) ? ext_we    : 1'b0;
      check("cpu_gnt", k, cpu_gnt[k], (g[k] == 1));
      check("ext_gnt", k, ext_gnt[k], (g[k] == 2));
      check("mem_addr", k, mem_addr[k], a);
      check("mem_wdata", k, mem_wdata[k], wd);
      check("mem_we", k, mem_we[k], we);
      check("mem_re", k, mem_re[k], (g[k] != 0) && !we);
      check("cpu_rvalid", k, cpu_rvalid[k], exp_crv[k]);
      check("ext_rvalid", k, ext_rvalid[k], exp_erv[k]);
      if (exp_crv[k]) check("cpu_rdata", k, cpu_rdata[k], exp_rd[k]);
      if (exp_erv[k]) check("ext_rdata", k, ext_rdata[k], exp_rd[k]);
      check("owner", k, dbg_owner[k], m_owner[k]);
      check("wait_cnt", k, dbg_wait[k], m_wait[k]);

      exp_crv[k] = (g[k] == 1) && !cpu_we;
      exp_erv[k] = (g[k] == 2) && !ext_we;
      if (g[k] != 0 && !we) exp_rd[k] = shadow[k][a];
      if (g[k] != 0 && we) shadow[k][a] = wd;
      if (g[k] == 2) m_burst[k] = (m_owner[k] == 2) ? ((m_burst[k] < MAXB) ? m_burst[k] + 1 : MAXB) : 1;
      else m_burst[k] = 0;
      if (ext_req && g[k] != 2) m_wait[k] = (m_wait[k] < STV) ? m_wait[k] + 1 : STV;
      else m_wait[k] = 0;
      m_owner[k] = g[k];
      if (g[k] != 0) m_last[k] = g[k];
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic er, input logic ew, input logic el, input logic [AW-1:0] ea);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = DW'($urandom);
    ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = DW'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 256; i++) begin
      pl_addr = AW'(i);
      pl_data = (i == 'h10) ? 8'h5A : DW'($urandom);
      shadow[0][i] = pl_data;
      shadow[1][i] = pl_data;
      @(posedge clock);
      #1;
    end
    pl_en = 1'b0;
    @(negedge clock);
    check_zero();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Both request every cycle without lock: alternation (RR) and starvation relief (prio).
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, AW'($urandom), 1, 0, 0, AW'($urandom));
      cycle();
    end

    // CPU read of a preloaded word, then idle to observe rvalid/rdata.
    drive(1, 0, 8'h10, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // EXT write followed by CPU readback.
    drive(0, 0, 0, 1, 1, 0, 8'h20);
    ext_wdata = 8'hC3;
    cycle();
    drive(1, 0, 8'h20, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Locked EXT burst interrupted by a pending CPU request.
    drive(0, 0, 0, 1, 1, 1, AW'($urandom));
    cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, AW'($urandom), 1, $urandom_range(0, 1), 1, AW'($urandom));
      cycle();
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), AW'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
            AW'($urandom));
      cycle();
    end

    // Reset lands right after a CPU read grant: no rvalid may follow.
    drive(1, 0, AW'($urandom), 0, 0, 0, 0);
    @(negedge clock);
    for (int k = 0; k < 2; k++) check("pre_rst_cpu_gnt", k, cpu_gnt[k], 1);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_zero();
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
